// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: scans N_DIG BCD digits through one shared 74HC4511-style
// decoder. Each digit slot is DIV clocks long. The slot starts with a blanked
// ghost guard of BLANK_CYC clocks. One clock follows with the latch open
// (LE=0), then the digit is shown for the rest of the slot. The first frame
// after reset is a lamp test. Leading-zero blanking is optional.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_digits_in         BCD digits, [3:0] = digit 0 (LSD)
//   i_load              capture i_digits_in into the pending register
//   i_lzb_en            leading-zero blanking enable
//   i_lt_req            lamp-test request, affects SHOW cycles only
//   o_d, o_le           decoder data and latch enable (1 = hold)
//   o_bi_n, o_lt_n      decoder blanking / lamp test, active-low
//   o_dig_sel           one-hot common-cathode digit enable
//   o_frame_done        pulse after the last slot of a frame
//   o_busy_lt           high during the power-up lamp-test frame
module seg_scan_ctrl #(
  parameter int unsigned N_DIG     = 4,
  parameter int unsigned DIV       = 1000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [4*N_DIG-1:0] i_digits_in,
  input  logic               i_load,
  input  logic               i_lzb_en,
  input  logic               i_lt_req,
  output logic [3:0]         o_d,
  output logic               o_le,
  output logic               o_bi_n,
  output logic               o_lt_n,
  output logic [N_DIG-1:0]   o_dig_sel,
  output logic               o_frame_done,
  output logic               o_busy_lt
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = $clog2(N_DIG);
  localparam int unsigned DW    = 4 * N_DIG;

  typedef enum logic {LAMP, SCAN} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_slot_cnt;
  logic [IDX_W-1:0]   r_dig_idx;
  logic [DW-1:0]      r_pending;
  logic [DW-1:0]      r_active;

  logic               w_slot_wrap;
  logic               w_frame_end;
  logic [3:0]         w_cur_digit;
  logic               w_blank_lz;
  logic [N_DIG-1:0]   w_onehot;

  logic [3:0]         w_d_nxt;
  logic               w_le_nxt;
  logic               w_bi_n_nxt;
  logic               w_lt_n_nxt;
  logic [N_DIG-1:0]   w_sel_nxt;
  logic               w_frame_done_nxt;
  logic               w_busy_nxt;

  assign w_slot_wrap = (r_slot_cnt == CNT_W'(DIV - 1));
  assign w_frame_end = w_slot_wrap && (r_dig_idx == IDX_W'(N_DIG - 1));
  assign w_onehot    = N_DIG'(1) << r_dig_idx;

  // Current digit value and its leading-zero status, both from the active register
  always_comb begin
    logic w_run;
    w_run       = 1'b1;
    w_cur_digit = 4'h0;
    w_blank_lz  = 1'b0;
    for (int i = N_DIG - 1; i >= 0; i--) begin
      w_run = w_run & (r_active[4*i +: 4] == 4'h0);
      if (r_dig_idx == IDX_W'(i)) begin
        w_cur_digit = r_active[4*i +: 4];
        w_blank_lz  = i_lzb_en && (i != 0) && w_run;
      end
    end
  end

  // Next state and next output values for the current slot phase
  always_comb begin
    w_state_nxt      = r_state;
    w_d_nxt          = o_d;
    w_le_nxt         = 1'b1;
    w_bi_n_nxt       = 1'b0;
    w_lt_n_nxt       = 1'b1;
    w_sel_nxt        = '0;
    w_frame_done_nxt = w_frame_end;
    w_busy_nxt       = (r_state == LAMP) && !w_frame_end;

    case (r_state)
      LAMP: if (w_frame_end) w_state_nxt = SCAN;
      SCAN: w_state_nxt = SCAN;
    endcase

    if (r_slot_cnt == CNT_W'(BLANK_CYC)) begin
      w_le_nxt = 1'b0;
      w_d_nxt  = w_cur_digit;
    end else if (r_slot_cnt > CNT_W'(BLANK_CYC)) begin
      if (r_state == LAMP || i_lt_req) begin
        w_lt_n_nxt = 1'b0;
        w_bi_n_nxt = 1'b1;
      end else begin
        w_bi_n_nxt = !w_blank_lz;
      end
      // A zero-blanked digit keeps its cathode off so dig_sel never overlaps BI_n=0
      w_sel_nxt = w_bi_n_nxt ? w_onehot : '0;
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= LAMP;
    else       r_state <= w_state_nxt;
  end

  // Slot/digit counters, update path and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_slot_cnt   <= '0;
      r_dig_idx    <= '0;
      r_pending    <= '0;
      r_active     <= '0;
      o_d          <= 4'h0;
      o_le         <= 1'b1;
      o_bi_n       <= 1'b0;
      o_lt_n       <= 1'b1;
      o_dig_sel    <= '0;
      o_frame_done <= 1'b0;
      o_busy_lt    <= 1'b1;
    end else begin
      r_slot_cnt <= w_slot_wrap ? '0 : r_slot_cnt + CNT_W'(1);
      if (w_slot_wrap)
        r_dig_idx <= (r_dig_idx == IDX_W'(N_DIG - 1)) ? '0 : r_dig_idx + IDX_W'(1);
      if (i_load)
        r_pending <= i_digits_in;
      // Transfer only at the frame boundary; a same-clock load lands next frame
      if (w_frame_end)
        r_active <= r_pending;
      o_d          <= w_d_nxt;
      o_le         <= w_le_nxt;
      o_bi_n       <= w_bi_n_nxt;
      o_lt_n       <= w_lt_n_nxt;
      o_dig_sel    <= w_sel_nxt;
      o_frame_done <= w_frame_done_nxt;
      o_busy_lt    <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with N_DIG=4, DIV=8, BLANK_CYC=2.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = 16'h0;
  logic        load = 1'b0;
  logic        lzb_en = 1'b0;
  logic        lt_req = 1'b0;
  logic [3:0]  d;
  logic        le, bi_n, lt_n, frame_done, busy_lt;
  logic [3:0]  dig_sel;

  int n_assert = 0;
  int n_fail   = 0;

  seg_scan_ctrl #(.N_DIG(4), .DIV(8), .BLANK_CYC(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_digits_in(digits_in), .i_load(load),
    .i_lzb_en(lzb_en), .i_lt_req(lt_req), .o_d(d), .o_le(le), .o_bi_n(bi_n),
    .o_lt_n(lt_n), .o_dig_sel(dig_sel), .o_frame_done(frame_done),
    .o_busy_lt(busy_lt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Digit select must be dark whenever the decoder is blanked or the latch is open
  always @(negedge clk) begin
    if (!rst) begin
      n_assert++;
      assert (!(dig_sel != 4'b0 && (bi_n !== 1'b1 || le !== 1'b1)))
      else begin
        n_fail++;
        $error("FAIL invariant dig_sel=%b bi_n=%b le=%b", dig_sel, bi_n, le);
      end
    end
  end

  // Walk one digit slot (up to 8 clocks) and check every phase
  task automatic check_slot(input int dig, input logic [3:0] d_exp, input logic show_bi,
                            input logic show_ltn, input logic lamp, input int n_ticks,
                            input logic bnd_load, input logic [15:0] bnd_val);
    logic [3:0] sel_exp;
    string      p;
    sel_exp = show_bi ? (4'b0001 << dig) : 4'b0000;
    for (int t = 0; t < n_ticks; t++) begin
      if (t == 7 && bnd_load) begin
        load = 1'b1;
        digits_in = bnd_val;
      end
      tick();
      if (t == 7 && bnd_load) load = 1'b0;
      p = $sformatf("d%0d_t%0d", dig, t);
      if (t < 2) begin
        chk({p, "_blank_bi"},  16'(bi_n), 16'(1'b0));
        chk({p, "_blank_le"},  16'(le), 16'(1'b1));
        chk({p, "_blank_sel"}, 16'(dig_sel), 16'h0);
        chk({p, "_blank_ltn"}, 16'(lt_n), 16'(1'b1));
      end else if (t == 2) begin
        chk({p, "_latch_le"},  16'(le), 16'(1'b0));
        chk({p, "_latch_d"},   16'(d), 16'(d_exp));
        chk({p, "_latch_sel"}, 16'(dig_sel), 16'h0);
        chk({p, "_latch_bi"},  16'(bi_n), 16'(1'b0));
        chk({p, "_latch_ltn"}, 16'(lt_n), 16'(1'b1));
      end else begin
        chk({p, "_show_le"},  16'(le), 16'(1'b1));
        chk({p, "_show_d"},   16'(d), 16'(d_exp));
        chk({p, "_show_bi"},  16'(bi_n), 16'(show_bi));
        chk({p, "_show_ltn"}, 16'(lt_n), 16'(show_ltn));
        chk({p, "_show_sel"}, 16'(dig_sel), 16'(sel_exp));
      end
      chk({p, "_frame_done"}, 16'(frame_done), 16'(t == 7 && dig == 3));
      chk({p, "_busy_lt"},    16'(busy_lt), 16'(lamp && !(t == 7 && dig == 3)));
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_d"},    16'(d), 16'h0);
    chk({tag, "_le"},   16'(le), 16'(1'b1));
    chk({tag, "_bi"},   16'(bi_n), 16'(1'b0));
    chk({tag, "_ltn"},  16'(lt_n), 16'(1'b1));
    chk({tag, "_sel"},  16'(dig_sel), 16'h0);
    chk({tag, "_fd"},   16'(frame_done), 16'(1'b0));
    chk({tag, "_busy"}, 16'(busy_lt), 16'(1'b1));
  endtask

  initial begin
    // Reset
    tick();
    tick();
    check_reset_vals("rst");
    rst = 1'b0;

    // Lamp frame; load 1234 during digit 0 slot
    load = 1'b1; digits_in = 16'h1234;
    check_slot(0, 4'h0, 1'b1, 1'b0, 1'b1, 8, 1'b0, 16'h0);
    load = 1'b0;
    for (int k = 1; k < 4; k++) check_slot(k, 4'h0, 1'b1, 1'b0, 1'b1, 8, 1'b0, 16'h0);

    // Normal scan of 1234; queue 0050
    load = 1'b1; digits_in = 16'h0050;
    check_slot(0, 4'h4, 1'b1, 1'b1, 1'b0, 8, 1'b0, 16'h0);
    load = 1'b0;
    check_slot(1, 4'h3, 1'b1, 1'b1, 1'b0, 8, 1'b0, 16'h0);
    check_slot(2, 4'h2, 1'b1, 1'b1, 1'b0, 8, 1'b0, 16'h0);
    check_slot(3, 4'h1, 1'b1, 1'b1, 1'b0, 8, 1'b0, 16'h0);

    // Leading-zero blanking on 0050; queue 0000
    lzb_en = 1'b1;
    load = 1'b1; digits_in = 16'h0000;
    check_slot(0, 4'h0, 1'b1, 1'b1, 1'b0, 8, 1'b0, 16'h0);
    load = 1'b0;
    check_slot(1, 4'h5, 1'b1, 1'b1, 1'b0, 8, 1'b0, 16'h0);
    check_slot(2, 4'h0, 1'b0, 1'b1, 1'b0, 8, 1'b0, 16'h0);
    check_slot(3, 4'h0, 1'b0, 1'b1, 1'b0, 8, 1'b0, 16'h0);

    // All zero: only digit 0 lit; pending 1111, then AAAA on the boundary clock
    load = 1'b1; digits_in = 16'h1111;
    check_slot(0, 4'h0, 1'b1, 1'b1, 1'b0, 8, 1'b0, 16'h0);
    load = 1'b0;
    check_slot(1, 4'h0, 1'b0, 1'b1, 1'b0, 8, 1'b0, 16'h0);
    check_slot(2, 4'h0, 1'b0, 1'b1, 1'b0, 8, 1'b0, 16'h0);
    check_slot(3, 4'h0, 1'b0, 1'b1, 1'b0, 8, 1'b1, 16'hAAAA);

    // Tearing: 1111 first, then AAAA
    for (int k = 0; k < 4; k++) check_slot(k, 4'h1, 1'b1, 1'b1, 1'b0, 8, 1'b0, 16'h0);
    load = 1'b1; digits_in = 16'h0007;
    check_slot(0, 4'hA, 1'b1, 1'b1, 1'b0, 8, 1'b0, 16'h0);
    load = 1'b0;
    for (int k = 1; k < 4; k++) check_slot(k, 4'hA, 1'b1, 1'b1, 1'b0, 8, 1'b0, 16'h0);

    // Lamp test overrides zero blanking on 0007
    lt_req = 1'b1;
    check_slot(0, 4'h7, 1'b1, 1'b0, 1'b0, 8, 1'b0, 16'h0);
    for (int k = 1; k < 4; k++) check_slot(k, 4'h0, 1'b1, 1'b0, 1'b0, 8, 1'b0, 16'h0);
    lt_req = 1'b0;

    // Mid-scan reset at slot_cnt=5 of digit 2
    check_slot(0, 4'h7, 1'b1, 1'b1, 1'b0, 8, 1'b0, 16'h0);
    check_slot(1, 4'h0, 1'b0, 1'b1, 1'b0, 8, 1'b0, 16'h0);
    check_slot(2, 4'h0, 1'b0, 1'b1, 1'b0, 5, 1'b0, 16'h0);
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    lzb_en = 1'b0;

    // Lamp frame restarts at digit 0, then pending (cleared) shows as 0000
    for (int k = 0; k < 4; k++) check_slot(k, 4'h0, 1'b1, 1'b0, 1'b1, 8, 1'b0, 16'h0);
    for (int k = 0; k < 4; k++) check_slot(k, 4'h0, 1'b1, 1'b1, 1'b0, 8, 1'b0, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
